// File: rtl/cell_plotter.sv
// cell_plotter
//   Sits between the life simulation stage and vga_adapter. It takes
//   cell-change events over a valid/ready handshake and queues them in a
//   small FIFO. Each event becomes a CELL_SIZE x CELL_SIZE pixel square,
//   emitted row-major at one pixel per clock. On request it also sweeps the
//   whole 160x120 screen to black.
//
// Ports
//   clock, reset          system clock; asynchronous active-high reset
//   in_valid / in_ready   event handshake (in_ready = FIFO not full)
//   in_cell_x/y, in_colour  event payload: cell column/row and colour
//   clear_req             one-cycle pulse requesting a full-screen clear
//   x, y, colour, plot    registered pixel write to vga_adapter
//   busy                  FIFO non-empty, square/clear running, or clear pending
//   drop_err              sticky flag for accepted out-of-range events
module cell_plotter #(
  parameter int unsigned CELL_SIZE  = 4,
  parameter int unsigned GRID_W     = 40,
  parameter int unsigned GRID_H     = 30,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_cell_x,
  input  logic [7:0] in_cell_y,
  input  logic [2:0] in_colour,
  input  logic       clear_req,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       drop_err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = (CELL_SIZE > 1) ? $clog2(CELL_SIZE) : 1;

  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] CELL_MAX = CW'(CELL_SIZE - 1);
  localparam logic [7:0]    GRID_W_C = 8'(GRID_W);
  localparam logic [7:0]    GRID_H_C = 8'(GRID_H);
  localparam logic [7:0]    SCR_XMAX = 8'd159;
  localparam logic [6:0]    SCR_YMAX = 7'd119;

  typedef enum logic [1:0] {IDLE, PLOT, CLEAR} state_t;

  state_t state;

  // Event FIFO
  logic [7:0]    mem_x [FIFO_DEPTH];
  logic [7:0]    mem_y [FIFO_DEPTH];
  logic [2:0]    mem_c [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          fifo_full, fifo_empty;

  logic accept, in_range, push, pop;

  // Square / sweep counters and latched square origin
  logic [CW-1:0] dx, dy, dx_nxt, dy_nxt;
  logic [7:0]    cx, cx_nxt;
  logic [6:0]    cy, cy_nxt;
  logic [7:0]    base_x, new_bx;
  logic [6:0]    base_y, new_by;

  logic clear_pend;
  logic sq_last, clr_last, boundary, go_clear;

  assign fifo_full  = (count == DEPTH_C);
  assign fifo_empty = (count == '0);

  assign in_ready = !reset && !fifo_full;
  assign accept   = in_valid && in_ready;
  assign in_range = (in_cell_x < GRID_W_C) && (in_cell_y < GRID_H_C);
  assign push     = accept && in_range;

  assign sq_last  = (dx == CELL_MAX) && (dy == CELL_MAX);
  assign clr_last = (cx == SCR_XMAX) && (cy == SCR_YMAX);

  // A boundary is any cycle where the FSM is free to pick new work: idle,
  // or the final pixel of a square or sweep. Pending clears win over pops.
  assign boundary = (state == IDLE) ||
                    (state == PLOT  && sq_last) ||
                    (state == CLEAR && clr_last);
  assign go_clear = boundary && clear_pend;
  assign pop      = boundary && !clear_pend && !fifo_empty;

  assign new_bx = 8'(mem_x[rd_ptr] * CELL_SIZE);
  assign new_by = 7'(mem_y[rd_ptr] * CELL_SIZE);

  assign busy = !fifo_empty || (state != IDLE) || clear_pend;

  always_comb begin
    dx_nxt = dx + 1'b1;
    dy_nxt = dy;
    if (dx == CELL_MAX) begin
      dx_nxt = '0;
      dy_nxt = dy + 1'b1;
    end
    cx_nxt = cx + 8'd1;
    cy_nxt = cy;
    if (cx == SCR_XMAX) begin
      cx_nxt = '0;
      cy_nxt = cy + 7'd1;
    end
  end

  // Storage has no reset; only the pointers and count define its contents.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_x[wr_ptr] <= in_cell_x;
      mem_y[wr_ptr] <= in_cell_y;
      mem_c[wr_ptr] <= in_colour;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (accept && !in_range) drop_err <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      clear_pend <= 1'b0;
      dx         <= '0;
      dy         <= '0;
      cx         <= '0;
      cy         <= '0;
      base_x     <= '0;
      base_y     <= '0;
      x          <= '0;
      y          <= '0;
      colour     <= '0;
      plot       <= 1'b0;
    end else begin
      // A request on the entry edge survives and yields one more clear.
      if (go_clear)  clear_pend <= 1'b0;
      if (clear_req) clear_pend <= 1'b1;

      if (go_clear) begin
        state  <= CLEAR;
        cx     <= '0;
        cy     <= '0;
        x      <= '0;
        y      <= '0;
        colour <= '0;
        plot   <= 1'b1;
      end else if (pop) begin
        state  <= PLOT;
        base_x <= new_bx;
        base_y <= new_by;
        dx     <= '0;
        dy     <= '0;
        x      <= new_bx;
        y      <= new_by;
        colour <= mem_c[rd_ptr];
        plot   <= 1'b1;
      end else if (boundary) begin
        state <= IDLE;
        plot  <= 1'b0;
      end else if (state == PLOT) begin
        dx <= dx_nxt;
        dy <= dy_nxt;
        x  <= base_x + 8'(dx_nxt);
        y  <= base_y + 7'(dy_nxt);
      end else begin
        cx <= cx_nxt;
        cy <= cy_nxt;
        x  <= cx_nxt;
        y  <= cy_nxt;
      end
    end
  end

endmodule

// File: tb/tb_cell_plotter.sv
// Directed testbench for cell_plotter (default parameters, CELL_SIZE = 4).
module tb_cell_plotter;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_cell_x;
  logic [7:0] in_cell_y;
  logic [2:0] in_colour;
  logic       clear_req;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       drop_err;

  cell_plotter #(
    .CELL_SIZE (4),
    .GRID_W    (40),
    .GRID_H    (30),
    .FIFO_DEPTH(8)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_cell_x(in_cell_x),
    .in_cell_y(in_cell_y),
    .in_colour(in_colour),
    .clear_req(clear_req),
    .x        (x),
    .y        (y),
    .colour   (colour),
    .plot     (plot),
    .busy     (busy),
    .drop_err (drop_err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {int px; int py; int pc; int pcyc;} pix_t;
  pix_t pix[$];

  always @(negedge clock)
    if (plot === 1'b1) pix.push_back('{int'(x), int'(y), int'(colour), cyc});

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Presents an event and holds it until accepted; acc = accepting edge.
  task automatic send(input int cx, input int cy, input int c, output int acc);
    int n = 0;
    in_valid  = 1'b1;
    in_cell_x = 8'(cx);
    in_cell_y = 8'(cy);
    in_colour = 3'(c);
    while (!in_ready && n < 1000) begin
      tick();
      n++;
    end
    if (n == 1000) check("send_ready_timeout", 32'(in_ready), 1);
    tick();
    acc = cyc;
  endtask

  task automatic wait_idle(input string tag, input int limit, output int fall);
    int n = 0;
    while (busy && n < limit) begin
      tick();
      n++;
    end
    check(tag, 32'(busy), 0);
    fall = cyc;
  endtask

  // Number of wrong pixels in a 4x4 square expected at pix[start...].
  function automatic int sq_bad(int start, int bx, int by, int c, int cyc0);
    int bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (start + i >= pix.size()) bad++;
      else if (pix[start+i].px != bx + i % 4 || pix[start+i].py != by + i / 4 ||
               pix[start+i].pc != c || pix[start+i].pcyc != cyc0 + i) bad++;
    end
    return bad;
  endfunction

  int a, a1, a2, a9, fall, bad;
  int acc[9];

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_cell_x = '0;
    in_cell_y = '0;
    in_colour = '0;
    clear_req = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_x", 32'(x), 0);
    check("rst_y", 32'(y), 0);
    check("rst_colour", 32'(colour), 0);
    check("rst_plot", 32'(plot), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_drop_err", 32'(drop_err), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    reset = 1'b0;
    tick();
    check("post_rst_in_ready", 32'(in_ready), 1);

    // Single event (2,3) -> x 8..11, y 12..15, first pixel after edge a+1
    pix.delete();
    send(2, 3, 7, a);
    in_valid = 1'b0;
    check("t1_busy_after_accept", 32'(busy), 1);
    check("t1_plot_not_yet", 32'(plot), 0);
    wait_idle("t1_idle", 100, fall);
    check("t1_pixel_count", pix.size(), 16);
    check("t1_square", sq_bad(0, 8, 12, 7, a + 1), 0);
    check("t1_busy_fall_edge", fall, a + 17);

    // Nine back-to-back events fill the FIFO; a tenth waits for the next pop
    pix.delete();
    for (int i = 0; i < 9; i++) send(i, i, (i % 2) ? 0 : 7, acc[i]);
    check("t2_ready_low_full", 32'(in_ready), 0);
    send(20, 10, 7, a9);
    in_valid = 1'b0;
    check("t2_held_accept_edge", a9, acc[0] + 18);
    wait_idle("t2_idle", 400, fall);
    check("t2_pixel_count", pix.size(), 160);
    bad = 0;
    for (int k = 0; k < 9; k++)
      bad += sq_bad(16 * k, k * 4, k * 4, (k % 2) ? 0 : 7, acc[0] + 1 + 16 * k);
    bad += sq_bad(144, 80, 40, 7, acc[0] + 145);
    check("t2_squares_contiguous", bad, 0);

    // Out-of-range event dropped, far-corner cell plotted
    pix.delete();
    send(40, 0, 7, a);
    in_valid = 1'b0;
    check("t3_drop_err", 32'(drop_err), 1);
    check("t3_not_enqueued_busy", 32'(busy), 0);
    repeat (4) tick();
    check("t3_no_pixels", pix.size(), 0);
    send(39, 29, 7, a);
    in_valid = 1'b0;
    wait_idle("t3_idle", 100, fall);
    check("t3_pixel_count", pix.size(), 16);
    check("t3_corner_square", sq_bad(0, 156, 116, 7, a + 1), 0);
    check("t3_drop_err_sticky", 32'(drop_err), 1);

    // Clear requested mid-square with two events queued
    pix.delete();
    send(1, 1, 7, a);
    send(5, 2, 7, a1);
    send(6, 3, 0, a2);
    in_valid = 1'b0;
    repeat (3) tick();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    check("t4_busy_pending", 32'(busy), 1);
    wait_idle("t4_idle", 20000, fall);
    check("t4_pixel_count", pix.size(), 16 + 19200 + 32);
    check("t4_first_square", sq_bad(0, 4, 4, 7, a + 1), 0);
    bad = 0;
    for (int i = 0; i < 19200; i++) begin
      if (16 + i >= pix.size()) bad++;
      else if (pix[16+i].px != i % 160 || pix[16+i].py != i / 160 ||
               pix[16+i].pc != 0 || pix[16+i].pcyc != a + 17 + i) bad++;
    end
    check("t4_clear_sweep", bad, 0);
    check("t4_second_square", sq_bad(19216, 20, 8, 7, a + 17 + 19200), 0);
    check("t4_third_square", sq_bad(19232, 24, 12, 0, a + 17 + 19216), 0);

    // Reset asserted mid-clear
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (50) tick();
    check("t6_clearing", 32'(plot), 1);
    #2 reset = 1'b1;
    #1;
    check("t6_async_plot", 32'(plot), 0);
    check("t6_async_in_ready", 32'(in_ready), 0);
    check("t6_async_busy", 32'(busy), 0);
    tick();
    reset = 1'b0;
    pix.delete();
    repeat (20) tick();
    check("t6_busy", 32'(busy), 0);
    check("t6_in_ready", 32'(in_ready), 1);
    check("t6_no_pixels", pix.size(), 0);
    check("t6_drop_err_cleared", 32'(drop_err), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
